fifo_wr_ctrl: RTL and testbench
===============================

// Module: fifo_wr_ctrl
// PURPOSE
//  Write-side control of the dual-clock FIFO. Sits upstream of the read control and feeds it.
//  Owns the gray-coded write pointer that the read domain synchronizes and compares against.
//  Synchronizes the read pointer into the write domain and derives fill level, full, almost-full.
//  Drives the write port of the shared RAM and flags overflow (write attempted while full).
// PARAMETERS
//  FIFO_ADDR_WD  3  pointer/address width; usable capacity = 2**FIFO_ADDR_WD - 1 entries
//  DATA_WD       8  data width passed through to the RAM write port
//  SYNC_STAGES   2  flop stages on rd_ptr_i (>=2)
//  AFULL_THRESH  6  almost-full when level >= this value (1..2**FIFO_ADDR_WD-1)
// PORTS
//  wr_clk        in   1             write-domain clock
//  wr_rst        in   1             async reset, active high
//  wr_en_i       in   1             write request; data on wr_data_i, one entry per cycle
//  wr_data_i     in   DATA_WD       write data
//  rd_ptr_i      in   FIFO_ADDR_WD  read pointer, gray, from read domain (async)
//  wr_ptr_o      out  FIFO_ADDR_WD  write pointer, gray, registered, to read domain
//  mem_we_o      out  1             RAM write strobe
//  mem_waddr_o   out  FIFO_ADDR_WD  RAM write address (= wr_ptr_o, gray-addressed RAM)
//  mem_wdata_o   out  DATA_WD       RAM write data (= wr_data_i)
//  wr_full_o     out  1             FIFO full (write-domain view)
//  wr_afull_o    out  1             almost full
//  wr_level_o    out  FIFO_ADDR_WD  entries held (write-domain view, pessimistic)
//  wr_ovf_o      out  1             sticky overflow flag
//  wr_ovf_clr_i  in   1             clears wr_ovf_o
// BEHAVIOUR
//  - One clock (wr_clk), async active-high reset wr_rst. All flops async-cleared to 0.
//  - Reset values: wr_ptr_o=0, sync chain=0, wr_level_o=0, wr_full_o=0, wr_afull_o=0, wr_ovf_o=0.
//    mem_we_o forced 0 while wr_rst high.
//  - Internal binary counter wr_bin; wr_ptr_o = bin2gray(wr_bin), both registered, updated together.
//  - rd_ptr_i passes SYNC_STAGES flops -> rd_ptr_sync; rd_bin_sync = gray2bin(rd_ptr_sync).
//    No logic between rd_ptr_i and first sync flop.
//  - wr_level_o = (wr_bin - rd_bin_sync) mod 2**FIFO_ADDR_WD, combinational from regs.
//  - wr_full_o = (wr_level_o == 2**FIFO_ADDR_WD-1), i.e. bin2gray(wr_bin+1) == rd_ptr_sync.
//    One slot always unused; matches read side, where empty = (rd_ptr == synced wr_ptr).
//  - wr_afull_o = (wr_level_o >= AFULL_THRESH).
//  - Accept = wr_en_i & ~wr_full_o. On accept: mem_we_o=1 same cycle (combinational),
//    mem_waddr_o = current wr_ptr_o, mem_wdata_o = wr_data_i. On next edge, wr_bin += 1.
//    wr_ptr_o advances one gray step (single-bit change), wraps 2**N-1 -> 0 in binary.
//  - Write while full: no RAM write, pointers hold, wr_ovf_o set on next edge.
//  - wr_ovf_o clears on edge with wr_ovf_clr_i=1; set and clear same cycle -> stays 1 (set wins).
//  - Latency: read-side pop visible in wr_full_o/wr_level_o SYNC_STAGES wr_clk edges after
//    rd_ptr_i changes. Full is conservative; never reports less occupancy than true.
//  - Write-side pushes counted in wr_level_o the cycle after the accepting edge.
//  - Reset mid-operation: pointers return to 0 asynchronously, in-flight write discarded.
//    Read control must be reset in the same event; required at system level.
// TESTING
//  1 Assert wr_rst mid-sim with wr_en_i=1 -> all outputs 0 immediately, mem_we_o=0.
//  2 rd_ptr_i=000, 8 back-to-back writes -> 7 accepted; mem_waddr_o 000,001,011,010,110,111,101.
//    wr_full_o=1 after 7th; 8th gives mem_we_o=0, wr_ovf_o=1 next edge, wr_ptr_o holds 100.
//  3 Full, then rd_ptr_i 000->001 -> wr_full_o stays 1 for 1 edge, drops after 2nd edge.
//    wr_level_o 7->6 at that edge.
//  4 AFULL_THRESH=6 -> wr_afull_o=0 at level 5, 1 at level 6, 0 again when level returns to 5.
//  5 Stream 20 writes with rd_ptr_i tracking -> wr_ptr_o wraps 100->000 with no flag glitch.
//    Data order on mem_wdata_o preserved; no overflow.
//  6 wr_ovf_o=1, wr_ovf_clr_i=1 with write-while-full -> stays 1.
//    wr_ovf_clr_i=1 alone -> 0 next edge.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// Write-side control of the dual-clock FIFO: gray write pointer, read-pointer
// synchronizer, fill level, full / almost-full and sticky overflow.
module fifo_wr_ctrl #(
    parameter int FIFO_ADDR_WD = 3,
    parameter int DATA_WD      = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 6
) (
    input  logic                    wr_clk,
    input  logic                    wr_rst,
    input  logic                    wr_en_i,
    input  logic [DATA_WD-1:0]      wr_data_i,
    input  logic [FIFO_ADDR_WD-1:0] rd_ptr_i,
    output logic [FIFO_ADDR_WD-1:0] wr_ptr_o,
    output logic                    mem_we_o,
    output logic [FIFO_ADDR_WD-1:0] mem_waddr_o,
    output logic [DATA_WD-1:0]      mem_wdata_o,
    output logic                    wr_full_o,
    output logic                    wr_afull_o,
    output logic [FIFO_ADDR_WD-1:0] wr_level_o,
    output logic                    wr_ovf_o,
    input  logic                    wr_ovf_clr_i
);

    localparam logic [FIFO_ADDR_WD-1:0] LEVEL_MAX = '1;
    localparam logic [FIFO_ADDR_WD-1:0] AFULL_LVL = FIFO_ADDR_WD'(AFULL_THRESH);

    function automatic logic [FIFO_ADDR_WD-1:0] bin2gray(
        input logic [FIFO_ADDR_WD-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    function automatic logic [FIFO_ADDR_WD-1:0] gray2bin(
        input logic [FIFO_ADDR_WD-1:0] g
    );
        logic [FIFO_ADDR_WD-1:0] b;
        b[FIFO_ADDR_WD-1] = g[FIFO_ADDR_WD-1];
        for (int i = FIFO_ADDR_WD - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [FIFO_ADDR_WD-1:0] wr_bin;
    logic [FIFO_ADDR_WD-1:0] rd_sync_q [SYNC_STAGES];
    logic [FIFO_ADDR_WD-1:0] rd_bin_sync;
    logic [FIFO_ADDR_WD-1:0] wr_bin_nxt;
    logic                    accept;

    // rd_ptr_i goes straight into the first flop; it is asynchronous here
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rd_sync_q[i] <= '0;
            end
        end else begin
            rd_sync_q[0] <= rd_ptr_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rd_sync_q[i] <= rd_sync_q[i-1];
            end
        end
    end

    assign rd_bin_sync = gray2bin(rd_sync_q[SYNC_STAGES-1]);

    // Level uses the stale read pointer, so it can only over-report occupancy
    assign wr_level_o = wr_bin - rd_bin_sync;
    assign wr_full_o  = (wr_level_o == LEVEL_MAX);
    assign wr_afull_o = (wr_level_o >= AFULL_LVL);

    assign accept     = wr_en_i & ~wr_full_o & ~wr_rst;
    assign wr_bin_nxt = wr_bin + 1'b1;

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            wr_bin   <= '0;
            wr_ptr_o <= '0;
        end else if (accept) begin
            wr_bin   <= wr_bin_nxt;
            wr_ptr_o <= bin2gray(wr_bin_nxt);
        end
    end

    // Set wins over clear so an overflow in the clearing cycle is not lost
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            wr_ovf_o <= 1'b0;
        end else if (wr_en_i & wr_full_o) begin
            wr_ovf_o <= 1'b1;
        end else if (wr_ovf_clr_i) begin
            wr_ovf_o <= 1'b0;
        end
    end

    assign mem_we_o    = accept;
    assign mem_waddr_o = wr_ptr_o;
    assign mem_wdata_o = wr_data_i;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Randomized bench for fifo_wr_ctrl: occupancy-count reference model plus
// a write scoreboard checked by an independent RAM-port monitor.
module tb_fifo_wr_ctrl;

    logic       wr_clk = 1'b0;
    logic       wr_rst;
    logic       wr_en_i;
    logic [7:0] wr_data_i;
    logic [2:0] rd_ptr_i;
    logic [2:0] wr_ptr_o;
    logic       mem_we_o;
    logic [2:0] mem_waddr_o;
    logic [7:0] mem_wdata_o;
    logic       wr_full_o;
    logic       wr_afull_o;
    logic [2:0] wr_level_o;
    logic       wr_ovf_o;
    logic       wr_ovf_clr_i;

    fifo_wr_ctrl #(
        .FIFO_ADDR_WD(3),
        .DATA_WD     (8),
        .SYNC_STAGES (2),
        .AFULL_THRESH(6)
    ) dut (
        .wr_clk      (wr_clk),
        .wr_rst      (wr_rst),
        .wr_en_i     (wr_en_i),
        .wr_data_i   (wr_data_i),
        .rd_ptr_i    (rd_ptr_i),
        .wr_ptr_o    (wr_ptr_o),
        .mem_we_o    (mem_we_o),
        .mem_waddr_o (mem_waddr_o),
        .mem_wdata_o (mem_wdata_o),
        .wr_full_o   (wr_full_o),
        .wr_afull_o  (wr_afull_o),
        .wr_level_o  (wr_level_o),
        .wr_ovf_o    (wr_ovf_o),
        .wr_ovf_clr_i(wr_ovf_clr_i)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t sbq[$];
    int  errors = 0;
    int  checks = 0;

    // Model: total words written / read as plain counts; read count seen
    // by the write side is the value from SYNC_STAGES edges ago.
    int  wr_cnt;
    int  rd_cnt;
    int  hist[$];
    bit  ovf_m;

    function automatic logic [2:0] gray3(input int c);
        logic [2:0] b;
        b = 3'(c % 8);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        wr_cnt = 0;
        rd_cnt = 0;
        ovf_m  = 1'b0;
        hist.delete();
        hist.push_back(0);
        hist.push_back(0);
    endtask

    task automatic cycle(input bit en, input bit pop, input bit clr);
        logic [7:0] d;
        int         lvl;
        bit         full;
        bit         acc;
        @(negedge wr_clk);
        d            = 8'($urandom);
        wr_en_i      = en;
        wr_data_i    = d;
        wr_ovf_clr_i = clr;
        if (pop && rd_cnt < wr_cnt) rd_cnt++;
        rd_ptr_i = gray3(rd_cnt);
        #1;
        lvl  = wr_cnt - hist[$];
        full = (lvl == 7);
        acc  = en && !full;
        chk("level", int'(wr_level_o), lvl);
        chk("full", int'(wr_full_o), int'(full));
        chk("afull", int'(wr_afull_o), int'(lvl >= 6));
        chk("ovf", int'(wr_ovf_o), int'(ovf_m));
        chk("wr_ptr", int'(wr_ptr_o), int'(gray3(wr_cnt)));
        chk("mem_we", int'(mem_we_o), int'(acc));
        if (acc) sbq.push_back('{gray3(wr_cnt), d});
        @(posedge wr_clk);
        if (acc) wr_cnt++;
        if (en && full) ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
        hist.push_front(rd_cnt);
        void'(hist.pop_back());
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr_ptr"}, int'(wr_ptr_o), 0);
        chk({tag, "_level"}, int'(wr_level_o), 0);
        chk({tag, "_full"}, int'(wr_full_o), 0);
        chk({tag, "_afull"}, int'(wr_afull_o), 0);
        chk({tag, "_ovf"}, int'(wr_ovf_o), 0);
        chk({tag, "_mem_we"}, int'(mem_we_o), 0);
        chk({tag, "_waddr"}, int'(mem_waddr_o), 0);
    endtask

    // RAM-port monitor: every strobe must match the oldest expected write
    initial begin
        wr_t e;
        forever begin
            @(negedge wr_clk);
            #2;
            if (mem_we_o) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %0h, none expected",
                             mem_waddr_o, mem_wdata_o);
                end else begin
                    e = sbq.pop_front();
                    if (mem_waddr_o !== e.addr || mem_wdata_o !== e.data) begin
                        errors++;
                        $display("FAIL ram_write: got addr %0d data %0h expected addr %0d data %0h",
                                 mem_waddr_o, mem_wdata_o, e.addr, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        wr_rst       = 1'b1;
        wr_en_i      = 1'b0;
        wr_data_i    = '0;
        rd_ptr_i     = '0;
        wr_ovf_clr_i = 1'b0;
        model_reset();
        repeat (3) @(posedge wr_clk);
        #1;
        check_all_zero("reset");
        @(negedge wr_clk);
        wr_rst = 1'b0;

        // Fill from empty: 7 accepted, 8th overflows
        repeat (8) cycle(1, 0, 0);
        cycle(0, 0, 0);

        // Clear together with write-while-full keeps the flag, clear alone drops it
        cycle(1, 0, 1);
        cycle(0, 0, 1);
        cycle(0, 0, 0);

        // One pop: full holds for one edge, then level 7 -> 6
        cycle(0, 1, 0);
        repeat (3) cycle(0, 0, 0);

        // Almost-full edges: 6 -> 5 -> 6 -> 5
        cycle(0, 1, 0);
        repeat (2) cycle(0, 0, 0);
        cycle(1, 0, 0);
        repeat (2) cycle(0, 0, 0);
        cycle(0, 1, 0);
        repeat (3) cycle(0, 0, 0);

        // Drain, then stream 20 writes with the reader tracking
        repeat (10) cycle(0, 1, 0);
        repeat (20) cycle(1, 1, 0);
        repeat (10) cycle(0, 1, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 16) == 0);
        end

        // Asynchronous reset mid-operation with a write pending
        repeat (6) cycle(1, 0, 0);
        @(negedge wr_clk);
        wr_en_i   = 1'b1;
        wr_data_i = 8'hA5;
        #1;
        wr_rst = 1'b1;
        #1;
        check_all_zero("midreset");
        rd_ptr_i = '0;
        model_reset();
        @(posedge wr_clk);
        #1;
        check_all_zero("midreset_edge");
        @(negedge wr_clk);
        wr_rst  = 1'b0;
        wr_en_i = 1'b0;

        for (int i = 0; i < 200; i++) begin
            cycle(($urandom % 3) != 0, ($urandom % 2) == 0, ($urandom % 8) == 0);
        end
        repeat (3) cycle(0, 0, 0);

        chk("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
